mtimer: RTL and testbench

- Memory-mapped RISC-V machine timer and software-interrupt source: the generator end of the interrupt lines consumed by the core interruptor.
- Holds 64-bit mtime, 64-bit mtimecmp and msip.
- Drives the timer interrupt (mip bit 7) and software interrupt (mip bit 3) into the core interrupt vector.
- Sits on the peripheral bus as a simple request/grant slave with single-outstanding accesses.

---
 rtl/mtimer_pkg.sv | 20 ++
 rtl/mtimer_if.sv | 17 +
 rtl/mtimer_prescaler.sv | 21 ++
 rtl/mtimer.sv | 93 +++++++++
 tb/tb_mtimer.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/mtimer_pkg.sv
// mtimer_pkg: register offsets, interrupt bit indices and byte-merge helper for the machine timer
package mtimer_pkg;
    typedef enum logic [4:0] {
        MTIMER_MSIP    = 5'h00,
        MTIMER_CMP_LO  = 5'h08,
        MTIMER_CMP_HI  = 5'h0C,
        MTIMER_TIME_LO = 5'h10,
        MTIMER_TIME_HI = 5'h14
    } mtimer_off_e;

    localparam int TIMER_IRQ_BIT = 7;
    localparam int SW_IRQ_BIT    = 3;

    function automatic logic [31:0] be_merge(input logic [31:0] old, input logic [31:0] wdata,
                                             input logic [3:0] be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? wdata[8*i +: 8] : old[8*i +: 8];
        return r;
    endfunction
endpackage

// File: rtl/mtimer_if.sv
// mtimer_if: request/grant peripheral bus with single-outstanding accesses
interface mtimer_if;
    logic        bus_req;
    logic        bus_gnt;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        bus_err;

    modport master(output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
                   input bus_gnt, bus_rvalid, bus_rdata, bus_err);
    modport slave(input bus_req, bus_we, bus_addr, bus_be, bus_wdata,
                  output bus_gnt, bus_rvalid, bus_rdata, bus_err);
endinterface

// File: rtl/mtimer_prescaler.sv
// mtimer_prescaler: divides clk into mtime ticks, frozen while halted
module mtimer_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic halt,
    output logic tick
);
    localparam int W = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

    logic [W-1:0] count;

    assign tick = (count == LAST) && !halt;

    // advance the phase on every non-halted cycle, wrapping after the last one
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) count <= '0;
        else if (!halt) count <= tick ? '0 : count + 1'b1;
endmodule

// File: rtl/mtimer.sv
// mtimer: RISC-V machine timer and software interrupt source; MTIMER_SNAPSHOT_EN adds a coherent hi-half snapshot
module mtimer
    import mtimer_pkg::*;
#(
    parameter int          PRESCALE  = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     halt,
    mtimer_if.slave  bus,
    output logic     irq_timer,
    output logic     irq_software
);
    logic        tick, acc, bad, wr, rd;
    logic [4:0]  off;
    logic [63:0] mtime, mtimecmp;
    logic        msip;
    logic [31:0] rval, hi_val, wmask;

    mtimer_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .halt (halt),
        .tick (tick)
    );

    assign off          = bus.bus_addr[4:0];
    assign bus.bus_gnt  = !bus.bus_rvalid;
    assign acc          = bus.bus_req && bus.bus_gnt;
    assign bad          = bus.bus_addr[1:0] != 2'b00 || bus.bus_addr[31:5] != BASE_ADDR[31:5] ||
                          !(off inside {MTIMER_MSIP, MTIMER_CMP_LO, MTIMER_CMP_HI, MTIMER_TIME_LO, MTIMER_TIME_HI});
    assign wr           = acc && bus.bus_we && !bad;
    assign rd           = acc && !bus.bus_we && !bad;
    assign irq_software = msip;

`ifdef MTIMER_SNAPSHOT_EN
    logic [31:0] shadow;

    // a lo read captures the hi half from the same sample so "lo then hi" is coherent
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) shadow <= '0;
        else if (rd && off == MTIMER_TIME_LO) shadow <= mtime[63:32];

    assign hi_val = shadow;
`else
    assign hi_val = mtime[63:32];
`endif

    // read mux over the register values present at the acceptance edge
    always_comb begin
        rval  = off == MTIMER_MSIP    ? {31'b0, msip} :
                off == MTIMER_CMP_LO  ? mtimecmp[31:0] :
                off == MTIMER_CMP_HI  ? mtimecmp[63:32] :
                off == MTIMER_TIME_LO ? mtime[31:0] : hi_val;
        wmask = be_merge(32'h0, 32'hFFFF_FFFF, bus.bus_be);
    end

    // one-cycle response after every accepted access; data only for good reads
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            bus.bus_rvalid <= 1'b0;
            bus.bus_err    <= 1'b0;
            bus.bus_rdata  <= '0;
        end else begin
            bus.bus_rvalid <= acc;
            bus.bus_err    <= acc && bad;
            bus.bus_rdata  <= rd ? rval : '0;
        end

    // software-visible control registers, byte-enabled writes
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            msip     <= 1'b0;
            mtimecmp <= '1;
        end else if (wr) begin
            if (off == MTIMER_MSIP && bus.bus_be[0]) msip <= bus.bus_wdata[0];
            if (off == MTIMER_CMP_LO) mtimecmp[31:0] <= be_merge(mtimecmp[31:0], bus.bus_wdata, bus.bus_be);
            if (off == MTIMER_CMP_HI) mtimecmp[63:32] <= be_merge(mtimecmp[63:32], bus.bus_wdata, bus.bus_be);
        end

    // a write to either half overrides the tick, and never carries across halves
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) mtime <= '0;
        else if (wr && off == MTIMER_TIME_LO) mtime[31:0] <= (mtime[31:0] & ~wmask) | (bus.bus_wdata & wmask);
        else if (wr && off == MTIMER_TIME_HI) mtime[63:32] <= (mtime[63:32] & ~wmask) | (bus.bus_wdata & wmask);
        else if (tick) mtime <= mtime + 64'd1;

    // level timer interrupt from the current register values
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) irq_timer <= 1'b0;
        else irq_timer <= mtime >= mtimecmp;
endmodule

// File: tb/tb_mtimer.sv
// tb_mtimer: randomized and directed checks of mtimer against a behavioural model
module tb_mtimer;
    import mtimer_pkg::*;

    localparam int          P    = 4;
    localparam logic [31:0] BASE = 32'h0200_0000;
`ifdef MTIMER_SNAPSHOT_EN
    localparam bit SNAP = 1'b1;
`else
    localparam bit SNAP = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0, halt = 1'b0;
    logic irq_timer, irq_software;
    int   checks = 0, passed = 0;

    mtimer_if bif();

    mtimer #(.PRESCALE(P), .BASE_ADDR(BASE)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .halt        (halt),
        .bus         (bif),
        .irq_timer   (irq_timer),
        .irq_software(irq_software)
    );

    always #5 clk = ~clk;

    logic [63:0] m_time, m_cmp;
    logic [31:0] m_shadow, m_rdata;
    logic        m_msip, m_rv, m_err, m_irq;
    int unsigned m_n;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w, input logic [3:0] be);
        logic [31:0] r = o;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = w[8*i +: 8];
        return r;
    endfunction

    task automatic model_reset();
        m_time = 0; m_cmp = '1; m_msip = 0; m_shadow = 0; m_n = 0;
        m_rv = 0; m_err = 0; m_rdata = 0; m_irq = 0;
    endtask

    task automatic model_step();
        logic        acc, bad, tick;
        logic [4:0]  o;
        logic [31:0] rv;
        logic [63:0] t;
        acc = bif.bus_req && !m_rv;
        o   = bif.bus_addr[4:0];
        bad = bif.bus_addr[1:0] != 0 || (bif.bus_addr >> 5) != (BASE >> 5) ||
              !(o == 0 || o == 8 || o == 12 || o == 16 || o == 20);
        case (o)
            5'd0:    rv = {31'b0, m_msip};
            5'd8:    rv = m_cmp[31:0];
            5'd12:   rv = m_cmp[63:32];
            5'd16:   rv = m_time[31:0];
            default: rv = SNAP ? m_shadow : m_time[63:32];
        endcase
        m_irq = m_time >= m_cmp;
        tick  = !halt && (m_n % P == P - 1);
        if (!halt) m_n++;
        t = tick ? m_time + 1 : m_time;
        m_rv    = acc;
        m_err   = acc && bad;
        m_rdata = (acc && !bad && !bif.bus_we) ? rv : 0;
        if (acc && !bad && !bif.bus_we && o == 16) m_shadow = m_time[63:32];
        if (acc && !bad && bif.bus_we)
            case (o)
                5'd0:  if (bif.bus_be[0]) m_msip = bif.bus_wdata[0];
                5'd8:  m_cmp[31:0]  = merge(m_cmp[31:0], bif.bus_wdata, bif.bus_be);
                5'd12: m_cmp[63:32] = merge(m_cmp[63:32], bif.bus_wdata, bif.bus_be);
                5'd16: t = {m_time[63:32], merge(m_time[31:0], bif.bus_wdata, bif.bus_be)};
                5'd20: t = {merge(m_time[63:32], bif.bus_wdata, bif.bus_be), m_time[31:0]};
                default: ;
            endcase
        m_time = t;
    endtask

    task automatic compare();
        chk("gnt", bif.bus_gnt, !m_rv);
        chk("rvalid", bif.bus_rvalid, m_rv);
        if (m_rv) begin
            chk("rdata", bif.bus_rdata, m_rdata);
            chk("err", bif.bus_err, m_err);
        end
        chk("irq_timer", irq_timer, m_irq);
        chk("irq_software", irq_software, m_msip);
    endtask

    task automatic cycle(input logic req, input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wd, input logic h);
        bif.bus_req = req; bif.bus_we = we; bif.bus_addr = addr;
        bif.bus_be = be; bif.bus_wdata = wd; halt = h;
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic idle(input int n, input logic h);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, h);
    endtask

    task automatic rd(input logic [4:0] o, input logic h);
        cycle(1, 0, BASE | 32'(o), 0, 0, h);
    endtask

    task automatic wr(input logic [4:0] o, input logic [31:0] d, input logic [3:0] be, input logic h);
        cycle(1, 1, BASE | 32'(o), be, d, h);
    endtask

    initial begin
        logic [4:0] offs [8] = '{5'h00, 5'h08, 5'h0C, 5'h10, 5'h14, 5'h04, 5'h18, 5'h02};
        bit risen;
        bif.bus_req = 0; bif.bus_we = 0; bif.bus_addr = 0; bif.bus_be = 0; bif.bus_wdata = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_gnt", bif.bus_gnt, 1);
        chk("reset_rvalid", bif.bus_rvalid, 0);
        chk("reset_rdata", bif.bus_rdata, 0);
        chk("reset_err", bif.bus_err, 0);
        chk("reset_irq_timer", irq_timer, 0);
        chk("reset_irq_software", irq_software, 0);
        rst_n = 1;

        idle(40, 0);
        rd(MTIMER_TIME_LO, 0);
        chk("time_after_40", bif.bus_rdata, 10);
        idle(8, 1);
        rd(MTIMER_TIME_LO, 0);
        chk("time_after_halt", bif.bus_rdata, 10);
        idle(3, 0);
        rd(MTIMER_TIME_LO, 0);
        chk("time_phase_kept", bif.bus_rdata, 11);

        chk("gnt_during_rvalid", bif.bus_gnt, 0);
        rd(MTIMER_TIME_LO, 0);
        chk("b2b_not_accepted", bif.bus_rvalid, 0);
        rd(MTIMER_MSIP, 0);
        chk("b2b_next_accepted", bif.bus_rvalid, 1);

        idle(1, 0);
        rd(5'h04, 0);
        chk("err_04", bif.bus_err, 1);
        chk("err_04_rdata", bif.bus_rdata, 0);
        idle(1, 0);
        rd(5'h18, 0);
        chk("err_18", bif.bus_err, 1);
        idle(1, 0);
        rd(5'h02, 0);
        chk("err_02", bif.bus_err, 1);
        idle(1, 0);
        cycle(1, 1, 32'h0300_0008, 4'hF, 0, 0);
        chk("err_base", bif.bus_err, 1);

        idle(1, 0);
        wr(MTIMER_CMP_HI, 0, 4'hF, 0);
        idle(1, 0);
        wr(MTIMER_CMP_LO, 20, 4'hF, 0);
        risen = 0;
        for (int i = 0; i < 200 && !risen; i++) begin
            idle(1, 0);
            risen = irq_timer;
        end
        chk("irq_rise_bound", risen, 1);
        wr(MTIMER_CMP_HI, 1, 4'hF, 0);
        chk("irq_hold_edge_n", irq_timer, 1);
        idle(1, 0);
        chk("irq_drop_edge_n1", irq_timer, 0);

        wr(MTIMER_TIME_LO, 32'hFFFF_FFFF, 4'hF, 1);
        idle(1, 1);
        wr(MTIMER_TIME_HI, 32'hFFFF_FFFF, 4'hF, 1);
        chk("wrap_write_ok", bif.bus_err, 0);
        idle(4, 0);
        rd(MTIMER_TIME_LO, 1);
        chk("wrap_lo", bif.bus_rdata, 0);
        idle(1, 1);
        rd(MTIMER_TIME_HI, 1);
        chk("wrap_hi", bif.bus_rdata, 0);

        idle(1, 0);
        wr(MTIMER_MSIP, 1, 4'hF, 0);
        chk("msip_set", irq_software, 1);
        idle(1, 0);
        wr(MTIMER_MSIP, 0, 4'b0010, 0);
        chk("msip_be_skip", irq_software, 1);
        idle(1, 0);
        wr(MTIMER_MSIP, 0, 4'b0000, 0);
        chk("msip_be0_ok", bif.bus_err, 0);
        idle(1, 0);
        wr(MTIMER_MSIP, 0, 4'b0001, 0);
        chk("msip_clr", irq_software, 0);

        idle(1, 1);
        wr(MTIMER_TIME_LO, 32'hFFFF_FFFF, 4'hF, 1);
        idle(1, 1);
        wr(MTIMER_TIME_HI, 0, 4'hF, 1);
        idle(1, 1);
        rd(MTIMER_TIME_LO, 1);
        chk("snap_lo", bif.bus_rdata, 32'hFFFF_FFFF);
        idle(5, 0);
        rd(MTIMER_TIME_HI, 1);
        chk("snap_hi", bif.bus_rdata, SNAP ? 0 : 1);

        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                rd(MTIMER_TIME_LO, 0);
                bif.bus_req = 0;
                rst_n = 0;
                #1;
                chk("midreset_rvalid", bif.bus_rvalid, 0);
                chk("midreset_gnt", bif.bus_gnt, 1);
                chk("midreset_rdata", bif.bus_rdata, 0);
                chk("midreset_irq_timer", irq_timer, 0);
                chk("midreset_irq_software", irq_software, 0);
                model_reset();
                @(negedge clk);
                @(negedge clk);
                rst_n = 1;
            end
            cycle($urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1,
                  ($urandom_range(15, 0) == 0 ? 32'h0300_0000 : BASE) | 32'(offs[$urandom_range(7, 0)]),
                  4'($urandom), $urandom, $urandom_range(7, 0) == 0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
